operand_fetch_stage: RTL and testbench
======================================

# operand_fetch_stage

Decode/operand-fetch stage between the IF/ID latch and the execute stage of the pipelined CPU. It drives the register file read addresses, collects the registered read data one cycle later, and corrects it for same-edge write-back collisions. It also decodes the instruction fields and sign-extends the immediate, and it presents everything through the ID/EX pipeline register under stall and flush control.

## Interface
Parameters:
- `DW`, 32: datapath width.
- `AW`, 5: register address width.

Ports:
- `CLOCK`  in  1  single clock; everything samples on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `IfIdValid`  in  1  the IF/ID latch holds an instruction.
- `IfIdInstr`  in  32  instruction word.
- `IfIdPC`  in  32  instruction PC.
- `Stall`  in  1  hazard-unit stall; holds both internal stages.
- `Flush`  in  1  kills both internal stages; has priority over `Stall`.
- `Accept`  out  1  instruction taken this cycle; equals `IfIdValid & ~Stall & ~Busy`.
- `Busy`  out  1  internal replay in progress (macro-off build only; otherwise tied 0).
- `RegRead1`, `RegRead2`  out  AW  register file read addresses (rs, rt).
- `ReadOut1`, `ReadOut2`  in  DW  register file data; registered, so it reflects the addresses driven one edge earlier.
- `WbEnable`  in  1  write-back write strobe, the same one the register file sees.
- `WbAddr`  in  AW  write-back address.
- `WbData`  in  DW  write-back data.
- `IdExValid`  out  1  ID/EX register holds a live instruction.
- `IdExPC`  out  32  PC of that instruction.
- `IdExOpA`, `IdExOpB`  out  DW  rs and rt operand values.
- `IdExImm`  out  DW  sign-extended instr[15:0].
- `IdExRs`, `IdExRt`, `IdExRd`  out  AW  instr[25:21], [20:16], [15:11].
- `IdExShamt`  out  5  instr[10:6].
- `IdExOpcode`, `IdExFunct`  out  6  instr[31:26], instr[5:0].

## Operation
- Internal stage A holds the valid bit, PC, instruction and the bypass flags and data. Stage B is the ID/EX output register.
- Read-address mux:
  - `RegRead1/2` equal A.rs/A.rt when A is valid and held (`Stall` or `Busy`).
  - Otherwise they equal IfIdInstr[25:21]/[20:16].
- On every edge, A recomputes its bypass for each operand:
  - Condition: `WbEnable` and `WbAddr` equals the address driven and that address is nonzero.
  - If true, it sets the flag and captures `WbData`; if false, it clears the flag.
- This covers the case where the register file reads the old value on the edge it writes.
- Operand formation for B: address 0 gives 0; a set flag gives the captured data; otherwise `ReadOut`.
- Stage advance, when `Flush`=0 and `Stall`=0:
  - B takes the formed A contents.
  - A takes IF/ID if `Accept`, else becomes invalid.
- `Stall`=1, `Flush`=0: A and B hold. The bypass flags still update, because the register file re-reads the held addresses.
- `Flush`=1: A and B valid bits clear on that edge; data fields are don't-care. `Accept` is not forced to 0, but an accepted instruction is discarded.
- Invalid stages pass no side effects. The `IdEx*` data fields of a bubble are 0.

## Timing
- Reset (async assert) makes every output 0, including `IdExValid`, `RegRead1/2` and `Busy`. Both stages become invalid. Release is synchronous to the next edge.
- Latency: an instruction accepted at edge k is visible on `IdEx*` after edge k+1, if there are no stalls.
- Throughput: one instruction per cycle.
- `Stall` held N cycles adds N cycles of latency and loses no instruction.
- `Stall` and `Flush` in the same cycle: flush wins.
- A write-back at edge k+1 to a register read by A is not bypassed. `ReadOut` already reflects it after k+1, and B captures `ReadOut`.

## Configuration
- `OF_WB_BYPASS_EN` defined: the bypass is as above and `Busy` is tied 0.
- `OF_WB_BYPASS_EN` undefined: no bypass data path. A 2-state FSM (RUN, REPLAY) handles collisions instead:
  - In RUN, a collision detected at capture moves the FSM to REPLAY and asserts `Busy` for one cycle.
  - In REPLAY, A holds, the read is re-issued, and B receives a bubble on that edge.
  - The next edge returns the FSM to RUN and advances normally.
  - `Flush` in REPLAY returns the FSM to RUN and clears A.
  - Stall in REPLAY holds the FSM in REPLAY.
- Cost: +1 cycle per collision.

## Test plan
- Reset mid-run with B valid: drive `RESET`=0 asynchronously → all outputs 0 immediately; first accept after release reaches `IdExValid` two edges later.
- Streaming: issue `addi` instructions with imm 0xFFF0 from PC 0x100, 0x104, 0x108 → `IdExImm`=0xFFFFFFF0, PCs in order, one per cycle, latency 2.
- Collision: accept an instruction reading rs=3 on the same edge that WB writes r3=0xDEADBEEF → `IdExOpA`=0xDEADBEEF.
  - Bypass on: no bubble.
  - Bypass off: `Busy` for 1 cycle and exactly one bubble.
- r0 guard: WB writes r0=0x1234 on the collision edge while reading rs=0 → `IdExOpA`=0.
- `Stall` for 3 cycles with a WB write to the held rt=5 (0x55) in the middle → `IdExOpB`=0x55 after release; no duplicate and no lost instruction.
- `Flush` and `Stall` asserted together with A and B valid → `IdExValid`=0 on the next edge, and the stream resumes from the next accept.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode / operand-fetch stage between the IF/ID latch
// and execute. Drives register file read addresses, forms operands one cycle
// later, decodes instruction fields and presents them through ID/EX.
//
// Optional feature macro: OF_WB_BYPASS_EN
//   defined   -> same-edge write-back collisions are forwarded from captured
//                WbData; Busy is tied 0.
//   undefined -> no forwarding path; a collision forces a re-read (REPLAY).
//
// state  | meaning
// -------+----------------------------------------------------------------
// RUN    | normal flow; ReadOut for the instruction in A is up to date
// REPLAY | A holds and re-reads its operands; ID/EX receives a bubble
// (the FSM exists only when OF_WB_BYPASS_EN is undefined)
module operand_fetch_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          IfIdValid,
   input  logic [31:0]   IfIdInstr,
   input  logic [31:0]   IfIdPC,
   input  logic          Stall,
   input  logic          Flush,
   output logic          Accept,
   output logic          Busy,
   output logic [AW-1:0] RegRead1,
   output logic [AW-1:0] RegRead2,
   input  logic [DW-1:0] ReadOut1,
   input  logic [DW-1:0] ReadOut2,
   input  logic          WbEnable,
   input  logic [AW-1:0] WbAddr,
   input  logic [DW-1:0] WbData,
   output logic          IdExValid,
   output logic [31:0]   IdExPC,
   output logic [DW-1:0] IdExOpA,
   output logic [DW-1:0] IdExOpB,
   output logic [DW-1:0] IdExImm,
   output logic [AW-1:0] IdExRs,
   output logic [AW-1:0] IdExRt,
   output logic [AW-1:0] IdExRd,
   output logic [4:0]    IdExShamt,
   output logic [5:0]    IdExOpcode,
   output logic [5:0]    IdExFunct
);

   logic          a_valid;
   logic [31:0]   a_pc;
   logic [31:0]   a_instr;
   logic          busy_int;
   logic          accept_int;
   logic          hold_a;
   logic [AW-1:0] a_rs;
   logic [AW-1:0] a_rt;
   logic [AW-1:0] if_rs;
   logic [AW-1:0] if_rt;
   logic [AW-1:0] rd_addr1;
   logic [AW-1:0] rd_addr2;
   logic          col1;
   logic          col2;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [DW-1:0] imm_ext;

   assign a_rs    = AW'(a_instr[25:21]);
   assign a_rt    = AW'(a_instr[20:16]);
   assign if_rs   = AW'(IfIdInstr[25:21]);
   assign if_rt   = AW'(IfIdInstr[20:16]);
   assign imm_ext = {{(DW-16){a_instr[15]}}, a_instr[15:0]};

   assign accept_int = IfIdValid & ~Stall & ~busy_int;
   // A held: the register file must keep reading A's operands
   assign hold_a     = a_valid & (Stall | busy_int);
   assign rd_addr1   = hold_a ? a_rs : if_rs;
   assign rd_addr2   = hold_a ? a_rt : if_rt;

   // Register file reads the old value on the edge it writes; detect that
   assign col1 = WbEnable && (WbAddr == rd_addr1) && (rd_addr1 != '0);
   assign col2 = WbEnable && (WbAddr == rd_addr2) && (rd_addr2 != '0);

   // Combinational outputs are forced low while reset is asserted
   assign Accept   = RESET & accept_int;
   assign RegRead1 = RESET ? rd_addr1 : '0;
   assign RegRead2 = RESET ? rd_addr2 : '0;
   assign Busy     = busy_int;

`ifdef OF_WB_BYPASS_EN
   logic          byp1_flag;
   logic          byp2_flag;
   logic [DW-1:0] byp1_data;
   logic [DW-1:0] byp2_data;

   assign busy_int = 1'b0;

   // Per-edge bypass capture for the addresses read on that edge
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         byp1_flag <= 1'b0;
         byp2_flag <= 1'b0;
         byp1_data <= '0;
         byp2_data <= '0;
      end else begin
         byp1_flag <= col1;
         byp2_flag <= col2;
         if (col1) byp1_data <= WbData;
         if (col2) byp2_data <= WbData;
      end
   end

   assign op_a = (a_rs == '0) ? '0 : (byp1_flag ? byp1_data : ReadOut1);
   assign op_b = (a_rt == '0) ? '0 : (byp2_flag ? byp2_data : ReadOut2);
`else
   typedef enum logic {
      RUN    = 1'b0,
      REPLAY = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   unused_wbdata;

   assign unused_wbdata = ^WbData;

   // FSM state register
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next state: a collision on any edge that leaves A valid forces a re-read;
   // a fresh collision on the re-read itself leaves stale data, so stay
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (!Flush && (col1 || col2) && (accept_int || (a_valid && Stall)))
               state_d = REPLAY;
         end
         REPLAY: begin
            if (Flush)
               state_d = RUN;
            else if (!(col1 || col2) && !Stall)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign busy_int = (state_q == REPLAY);
   assign op_a     = (a_rs == '0) ? '0 : ReadOut1;
   assign op_b     = (a_rt == '0) ? '0 : ReadOut2;
`endif

   // Stage A: capture from IF/ID on accept, hold on stall or replay
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         a_valid <= 1'b0;
         a_pc    <= '0;
         a_instr <= '0;
      end else if (Flush) begin
         a_valid <= 1'b0;
      end else if (!(Stall || busy_int)) begin
         a_valid <= accept_int;
         if (accept_int) begin
            a_pc    <= IfIdPC;
            a_instr <= IfIdInstr;
         end
      end
   end

   // ID/EX register: bubble on flush, replay or empty A; hold on stall
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         IdExValid  <= 1'b0;
         IdExPC     <= '0;
         IdExOpA    <= '0;
         IdExOpB    <= '0;
         IdExImm    <= '0;
         IdExRs     <= '0;
         IdExRt     <= '0;
         IdExRd     <= '0;
         IdExShamt  <= '0;
         IdExOpcode <= '0;
         IdExFunct  <= '0;
      end else if (Flush || (!Stall && (busy_int || !a_valid))) begin
         IdExValid  <= 1'b0;
         IdExPC     <= '0;
         IdExOpA    <= '0;
         IdExOpB    <= '0;
         IdExImm    <= '0;
         IdExRs     <= '0;
         IdExRt     <= '0;
         IdExRd     <= '0;
         IdExShamt  <= '0;
         IdExOpcode <= '0;
         IdExFunct  <= '0;
      end else if (!Stall) begin
         IdExValid  <= 1'b1;
         IdExPC     <= a_pc;
         IdExOpA    <= op_a;
         IdExOpB    <= op_b;
         IdExImm    <= imm_ext;
         IdExRs     <= a_rs;
         IdExRt     <= a_rt;
         IdExRd     <= AW'(a_instr[15:11]);
         IdExShamt  <= a_instr[10:6];
         IdExOpcode <= a_instr[31:26];
         IdExFunct  <= a_instr[5:0];
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: instruction-level model (architectural
// register array, one pending instruction, ID/EX expectation) compared every
// cycle, plus directed scenarios with literal expectations.
module tb_operand_fetch_stage;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef OF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b0;
   logic          IfIdValid;
   logic [31:0]   IfIdInstr;
   logic [31:0]   IfIdPC;
   logic          Stall;
   logic          Flush;
   logic          Accept;
   logic          Busy;
   logic [AW-1:0] RegRead1;
   logic [AW-1:0] RegRead2;
   logic [DW-1:0] ReadOut1;
   logic [DW-1:0] ReadOut2;
   logic          WbEnable;
   logic [AW-1:0] WbAddr;
   logic [DW-1:0] WbData;
   logic          IdExValid;
   logic [31:0]   IdExPC;
   logic [DW-1:0] IdExOpA;
   logic [DW-1:0] IdExOpB;
   logic [DW-1:0] IdExImm;
   logic [AW-1:0] IdExRs;
   logic [AW-1:0] IdExRt;
   logic [AW-1:0] IdExRd;
   logic [4:0]    IdExShamt;
   logic [5:0]    IdExOpcode;
   logic [5:0]    IdExFunct;

   int n_pass  = 0;
   int n_total = 0;

   operand_fetch_stage #(.DW(DW), .AW(AW)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .IfIdValid(IfIdValid), .IfIdInstr(IfIdInstr),
      .IfIdPC(IfIdPC), .Stall(Stall), .Flush(Flush), .Accept(Accept), .Busy(Busy),
      .RegRead1(RegRead1), .RegRead2(RegRead2), .ReadOut1(ReadOut1), .ReadOut2(ReadOut2),
      .WbEnable(WbEnable), .WbAddr(WbAddr), .WbData(WbData), .IdExValid(IdExValid),
      .IdExPC(IdExPC), .IdExOpA(IdExOpA), .IdExOpB(IdExOpB), .IdExImm(IdExImm),
      .IdExRs(IdExRs), .IdExRt(IdExRt), .IdExRd(IdExRd), .IdExShamt(IdExShamt),
      .IdExOpcode(IdExOpcode), .IdExFunct(IdExFunct)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [31:0] pattern(input int i);
      return 32'(i) * 32'h0101_0101;
   endfunction

   // Register file device: registered read, write on the same edge; r0 is
   // stored like any other register so the stage's r0 guard is exercised
   logic [31:0] mem [32];
   always @(posedge CLOCK) begin
      if (!RESET) begin
         for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hBAD0_0000 : pattern(i);
         ReadOut1 <= '0;
         ReadOut2 <= '0;
      end else begin
         ReadOut1 <= mem[RegRead1];
         ReadOut2 <= mem[RegRead2];
         if (WbEnable) mem[WbAddr] <= WbData;
      end
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] opa;
      logic [31:0] opb;
   } bexp_t;

   logic [31:0] arch [32];
   logic        m_av;
   logic        m_rr;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   bexp_t       m_b;
   logic        exp_busy;
   logic        exp_acc;
   logic        exp_col;
   logic [4:0]  exp_ra1;
   logic [4:0]  exp_ra2;

   assign exp_busy = !BYP && m_av && m_rr;
   assign exp_acc  = RESET && IfIdValid && !Stall && !exp_busy;
   assign exp_ra1  = !RESET ? 5'd0 : (m_av && (Stall || exp_busy)) ? m_instr[25:21] : IfIdInstr[25:21];
   assign exp_ra2  = !RESET ? 5'd0 : (m_av && (Stall || exp_busy)) ? m_instr[20:16] : IfIdInstr[20:16];
   assign exp_col  = WbEnable && (WbAddr != 0) && ((WbAddr == exp_ra1) || (WbAddr == exp_ra2));

   // An instruction's operands are the architectural values just before the
   // edge it enters ID/EX; m_rr marks a pending instruction whose last read
   // collided (it must be re-read before it may issue, without a bypass)
   always @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         m_av    <= 1'b0;
         m_rr    <= 1'b0;
         m_pc    <= '0;
         m_instr <= '0;
         m_b     <= '0;
         for (int i = 0; i < 32; i++) arch[i] <= (i == 0) ? 32'h0 : pattern(i);
      end else begin
         if (WbEnable && WbAddr != 0) arch[WbAddr] <= WbData;
         if (Flush) begin
            m_b  <= '0;
            m_av <= 1'b0;
            m_rr <= 1'b0;
         end else if (Stall) begin
            if (m_av && exp_col) m_rr <= 1'b1;
         end else if (exp_busy) begin
            m_b  <= '0;
            m_rr <= exp_col;
         end else begin
            if (m_av) begin
               m_b.v     <= 1'b1;
               m_b.pc    <= m_pc;
               m_b.instr <= m_instr;
               m_b.opa   <= arch[m_instr[25:21]];
               m_b.opb   <= arch[m_instr[20:16]];
            end else begin
               m_b <= '0;
            end
            m_av <= exp_acc;
            m_rr <= exp_acc && exp_col;
            if (exp_acc) begin
               m_pc    <= IfIdPC;
               m_instr <= IfIdInstr;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
   endtask

   task automatic compare_all;
      logic [31:0] ei;
      ei = m_b.instr;
      check("m_valid", {31'd0, IdExValid}, {31'd0, m_b.v});
      check("m_pc", IdExPC, m_b.pc);
      check("m_opa", IdExOpA, m_b.opa);
      check("m_opb", IdExOpB, m_b.opb);
      check("m_imm", IdExImm, {{16{ei[15]}}, ei[15:0]});
      check("m_rs", 32'(IdExRs), 32'(ei[25:21]));
      check("m_rt", 32'(IdExRt), 32'(ei[20:16]));
      check("m_rd", 32'(IdExRd), 32'(ei[15:11]));
      check("m_shamt", 32'(IdExShamt), 32'(ei[10:6]));
      check("m_opcode", 32'(IdExOpcode), 32'(ei[31:26]));
      check("m_funct", 32'(IdExFunct), 32'(ei[5:0]));
      check("m_busy", {31'd0, Busy}, {31'd0, exp_busy});
      check("m_accept", {31'd0, Accept}, {31'd0, exp_acc});
      check("m_regread1", 32'(RegRead1), 32'(exp_ra1));
      check("m_regread2", 32'(RegRead2), 32'(exp_ra2));
   endtask

   // Per-cycle comparison, well away from the rising edge
   always @(negedge CLOCK) begin
      #2;
      compare_all();
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(negedge CLOCK);
   endtask

   task automatic idle;
      IfIdValid = 1'b0; IfIdInstr = '0; IfIdPC = '0;
      Stall = 1'b0; Flush = 1'b0;
      WbEnable = 1'b0; WbAddr = '0; WbData = '0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
      IfIdValid = 1'b1; IfIdPC = pc; IfIdInstr = instr;
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   int          nv;
   logic [31:0] pc0, pc1, opb0;
   logic        sent;
   int          sel;

   initial begin
      idle();
      IfIdValid = 1'b1;
      IfIdInstr = 32'hFFFF_FFFF;
      repeat (3) tick();
      check("rst_valid", {31'd0, IdExValid}, 32'd0);
      check("rst_regread1", 32'(RegRead1), 32'd0);
      check("rst_accept", {31'd0, Accept}, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      RESET = 1'b1;
      idle();
      tick();

      // Streaming addi, imm 0xFFF0
      drive(32'h100, mk(6'h08, 5'd1, 5'd2, 16'hFFF0)); tick();
      check("stream_latency", {31'd0, IdExValid}, 32'd0);
      drive(32'h104, mk(6'h08, 5'd1, 5'd2, 16'hFFF0)); tick();
      check("stream_valid0", {31'd0, IdExValid}, 32'd1);
      check("stream_pc0", IdExPC, 32'h100);
      check("stream_imm0", IdExImm, 32'hFFFF_FFF0);
      check("stream_opa0", IdExOpA, 32'h0101_0101);
      check("stream_opb0", IdExOpB, 32'h0202_0202);
      drive(32'h108, mk(6'h08, 5'd1, 5'd2, 16'hFFF0)); tick();
      check("stream_pc1", IdExPC, 32'h104);
      idle(); tick();
      check("stream_pc2", IdExPC, 32'h108);
      check("stream_imm2", IdExImm, 32'hFFFF_FFF0);
      tick();
      check("stream_drain", {31'd0, IdExValid}, 32'd0);

      // Same-edge collision on rs=3
      drive(32'h180, mk(6'h00, 5'd3, 5'd4, 16'h1820));
      WbEnable = 1'b1; WbAddr = 5'd3; WbData = 32'hDEAD_BEEF;
      tick();
      idle();
`ifdef OF_WB_BYPASS_EN
      check("col_busy", {31'd0, Busy}, 32'd0);
      tick();
`else
      check("col_busy", {31'd0, Busy}, 32'd1);
      tick();
      check("col_bubble", {31'd0, IdExValid}, 32'd0);
      check("col_busy_end", {31'd0, Busy}, 32'd0);
      tick();
`endif
      check("col_valid", {31'd0, IdExValid}, 32'd1);
      check("col_pc", IdExPC, 32'h180);
      check("col_opa", IdExOpA, 32'hDEAD_BEEF);
      tick();

      // r0 guard
      drive(32'h1C0, mk(6'h00, 5'd0, 5'd0, 16'h0000));
      WbEnable = 1'b1; WbAddr = 5'd0; WbData = 32'h0000_1234;
      tick();
      idle(); tick();
      check("r0_valid", {31'd0, IdExValid}, 32'd1);
      check("r0_opa", IdExOpA, 32'd0);
      check("r0_opb", IdExOpB, 32'd0);
      tick();

      // Stall 3 cycles with a write to held rt=5 in the middle
      drive(32'h200, mk(6'h00, 5'd6, 5'd5, 16'h0000)); tick();
      drive(32'h204, mk(6'h00, 5'd7, 5'd8, 16'h0000)); Stall = 1'b1; tick();
      WbEnable = 1'b1; WbAddr = 5'd5; WbData = 32'h55; tick();
      WbEnable = 1'b0; tick();
      Stall = 1'b0;
      nv = 0; pc0 = '0; pc1 = '0; opb0 = '0;
      for (int i = 0; i < 8; i++) begin
         #1 sent = Accept;
         tick();
         if (sent) IfIdValid = 1'b0;
         if (IdExValid) begin
            if (nv == 0) begin pc0 = IdExPC; opb0 = IdExOpB; end
            else if (nv == 1) pc1 = IdExPC;
            nv++;
         end
      end
      check("stall_count", 32'(nv), 32'd2);
      check("stall_pc0", pc0, 32'h200);
      check("stall_opb", opb0, 32'h55);
      check("stall_pc1", pc1, 32'h204);
      idle(); tick();

      // Flush together with Stall while A and B are valid
      drive(32'h300, mk(6'h00, 5'd9, 5'd10, 16'h0000)); tick();
      drive(32'h304, mk(6'h00, 5'd9, 5'd10, 16'h0000)); tick();
      check("flush_pre", IdExPC, 32'h300);
      drive(32'h308, mk(6'h00, 5'd9, 5'd10, 16'h0000)); Flush = 1'b1; Stall = 1'b1; tick();
      check("flush_valid", {31'd0, IdExValid}, 32'd0);
      Flush = 1'b0; Stall = 1'b0; tick();
      check("flush_a_killed", {31'd0, IdExValid}, 32'd0);
      drive(32'h30C, mk(6'h00, 5'd9, 5'd10, 16'h0000)); tick();
      check("flush_resume0", IdExPC, 32'h308);
      idle(); tick();
      check("flush_resume1", IdExPC, 32'h30C);
      tick();

      // Asynchronous reset mid-run with B valid
      drive(32'h400, mk(6'h00, 5'd11, 5'd12, 16'h8001)); tick();
      drive(32'h404, mk(6'h00, 5'd11, 5'd12, 16'h8001)); tick();
      check("mrst_pre", {31'd0, IdExValid}, 32'd1);
      #1 RESET = 1'b0;
      #1;
      check("mrst_valid", {31'd0, IdExValid}, 32'd0);
      check("mrst_pc", IdExPC, 32'd0);
      check("mrst_imm", IdExImm, 32'd0);
      check("mrst_regread1", 32'(RegRead1), 32'd0);
      check("mrst_accept", {31'd0, Accept}, 32'd0);
      tick(); tick();
      RESET = 1'b1;
      drive(32'h500, mk(6'h08, 5'd13, 5'd14, 16'h0007)); tick();
      idle();
      check("mrst_lat", {31'd0, IdExValid}, 32'd0);
      tick();
      check("mrst_first", IdExPC, 32'h500);
      tick();

      // Randomized traffic with biased write-back collisions
      for (int c = 0; c < 700; c++) begin
         IfIdValid = ($urandom_range(0, 99) < 70);
         IfIdPC    = $urandom;
         IfIdInstr = $urandom;
         Stall     = ($urandom_range(0, 99) < 15);
         Flush     = ($urandom_range(0, 99) < 5);
         WbEnable  = ($urandom_range(0, 99) < 50);
         sel       = int'($urandom_range(0, 3));
         case (sel)
            0:       WbAddr = IfIdInstr[25:21];
            1:       WbAddr = IfIdInstr[20:16];
            2:       WbAddr = m_instr[20:16];
            default: WbAddr = 5'($urandom);
         endcase
         WbData = $urandom;
         tick();
      end
      idle();
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
